hilo_unit: RTL and testbench

Multiply issue and HI/LO register unit for the EX stage of the pipelined MIPS core. It accepts MULT, MFHI and MFLO operations from EX and drives operands and a start pulse to the serial 16x16 signed multiplier. It waits for the multiplier's valid flag and writes the 32-bit product into the HI/LO registers. Any dependent operation that arrives while a multiply is in flight stalls the pipeline.

---
 rtl/hilo_pkg.sv | 8 +
 rtl/hilo_timeout_counter.sv | 20 ++
 rtl/hilo_unit.sv | 86 ++++++++
 tb/tb_hilo_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// hilo_pkg: shared op encodings, FSM states and defaults for the HI/LO multiply unit
package hilo_pkg;
  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_MFHI = 2'b01;
  localparam logic [1:0] OP_MFLO = 2'b10;
  localparam int TIMEOUT_DEFAULT = 40;
  typedef enum logic [1:0] {IDLE = 2'b00, START = 2'b01, BUSY = 2'b10} state_t;
endpackage

// File: rtl/hilo_timeout_counter.sv
// hilo_timeout_counter: counts BUSY cycles and flags the last one before the multiply is abandoned
module hilo_timeout_counter import hilo_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // clear wins over counting so every multiply starts from zero
  always_comb cnt_d = clear ? '0 : enable ? cnt_q + CW'(1) : cnt_q;
  // count register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = cnt_q == CW'(TIMEOUT - 1);
endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: issues MULT to the serial multiplier, holds HI/LO and interlocks dependent ops
module hilo_unit import hilo_pkg::*; #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   rs_val,
  input  logic [WIDTH-1:0]   rt_val,
  output logic               stall,
  output logic [WIDTH-1:0]   rd_val,
  output logic               rd_valid,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_result,
  input  logic               mul_valid,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               err
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
  logic err_q, err_d, expired, idle;
  assign idle = state_q == IDLE;
  hilo_timeout_counter #(.TIMEOUT(TIMEOUT)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == START),
    .enable  (state_q == BUSY),
    .expired (expired)
  );
  // next state: capture operands on accept, a valid result beats a coinciding timeout
  always_comb begin
    state_d = state_q;
    hi_d = hi_q;
    lo_d = lo_q;
    a_d = a_q;
    b_d = b_q;
    err_d = err_q;
    unique case (state_q)
      IDLE: if (op_valid && op == OP_MULT) begin
        state_d = START;
        a_d = rs_val;
        b_d = rt_val;
      end
      START: state_d = BUSY;
      BUSY: if (mul_valid) begin
        state_d = IDLE;
        {hi_d, lo_d} = mul_result;
      end else if (expired) begin
        state_d = IDLE;
        err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and architectural registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      hi_q <= '0;
      lo_q <= '0;
      a_q <= '0;
      b_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      a_q <= a_d;
      b_q <= b_d;
      err_q <= err_d;
    end
  assign stall = !idle && op_valid && op != 2'b11;
  assign rd_valid = idle && op_valid && (op == OP_MFHI || op == OP_MFLO);
  assign rd_val = !rd_valid ? '0 : op == OP_MFHI ? hi_q : lo_q;
  assign mul_start = state_q == START;
  assign mul_a = a_q;
  assign mul_b = b_q;
  assign hi = hi_q;
  assign lo = lo_q;
  assign err = err_q;
endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed and random checks of hilo_unit against a behavioural HI/LO model
module tb_hilo_unit;
  import hilo_pkg::*;
  localparam int W = 16;
  localparam int TO = 40;
  logic clk = 1'b0, rst = 1'b1, op_valid = 1'b0, mul_valid = 1'b0;
  logic [1:0] op = 2'b00;
  logic [W-1:0] rs_val = '0, rt_val = '0;
  logic [2*W-1:0] mul_result = '0;
  logic stall, rd_valid, mul_start, err;
  logic [W-1:0] rd_val, mul_a, mul_b, hi, lo;
  int n_cmp = 0, n_bad = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic m_err = 1'b0;

  always #5 clk = ~clk;

  hilo_unit #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .stall(stall), .rd_val(rd_val), .rd_valid(rd_valid), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result), .mul_valid(mul_valid),
    .hi(hi), .lo(lo), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // mode 0: quiet, 1: random ops, 2: hold op hop every cycle
  task automatic drive_busy(input int mode, input logic [1:0] hop);
    if (mode == 2) begin
      op_valid = 1'b1;
      op = hop;
    end else if (mode == 1) begin
      op_valid = 1'($urandom);
      op = 2'($urandom);
    end else op_valid = 1'b0;
    rs_val = W'($urandom);
    rt_val = W'($urandom);
  endtask

  // k: BUSY cycle (1-based) in which the multiplier reports; 0 means never
  task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b, input int k,
                         input int mode, input logic [1:0] hop);
    logic signed [2*W-1:0] p, t;
    bit fin;
    fin = 1'b0;
    p = $signed(a) * $signed(b);
    @(negedge clk);
    op_valid = 1'b1; op = OP_MULT; rs_val = a; rt_val = b;
    mul_valid = 1'b0; mul_result = $urandom;
    #1;
    chk("acc_stall", stall, 0);
    chk("acc_rdvalid", rd_valid, 0);
    chk("acc_hi", hi, m_hi);
    chk("acc_lo", lo, m_lo);
    chk("acc_err", err, m_err);
    @(negedge clk);
    drive_busy(mode, hop);
    #1;
    chk("start_pulse", mul_start, 1);
    chk("start_a", mul_a, a);
    chk("start_b", mul_b, b);
    chk("start_stall", stall, op_valid && op != 2'b11);
    chk("start_rdvalid", rd_valid, 0);
    for (int c = 1; c <= TO && !fin; c++) begin
      @(negedge clk);
      drive_busy(mode, hop);
      mul_valid = (c == k);
      if (c == k) begin
        t = $signed(mul_a) * $signed(mul_b);
        mul_result = t;
      end else mul_result = $urandom;
      #1;
      chk("busy_stall", stall, op_valid && op != 2'b11);
      chk("busy_rdvalid", rd_valid, 0);
      chk("busy_rdval", rd_val, 0);
      chk("busy_start", mul_start, 0);
      chk("busy_a", mul_a, a);
      chk("busy_b", mul_b, b);
      chk("busy_err", err, m_err);
      fin = (c == k);
    end
    if (fin) {m_hi, m_lo} = p;
    else m_err = 1'b1;
  endtask

  task automatic idle_op(input logic [1:0] o, input bit junk);
    @(negedge clk);
    op_valid = 1'b1; op = o; mul_valid = junk; mul_result = $urandom;
    #1;
    chk("idle_stall", stall, 0);
    chk("idle_rdvalid", rd_valid, o == OP_MFHI || o == OP_MFLO);
    chk("idle_rdval", rd_val, o == OP_MFHI ? m_hi : o == OP_MFLO ? m_lo : 16'h0);
    chk("idle_start", mul_start, 0);
  endtask

  task automatic quiet();
    @(negedge clk);
    op_valid = 1'b0; mul_valid = 1'b0;
    #1;
    chk("quiet_rdvalid", rd_valid, 0);
    chk("quiet_stall", stall, 0);
    chk("quiet_hi", hi, m_hi);
    chk("quiet_lo", lo, m_lo);
    chk("quiet_err", err, m_err);
  endtask

  initial begin
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_a", mul_a, 0);
    chk("rst_b", mul_b, 0);
    chk("rst_start", mul_start, 0);
    chk("rst_err", err, 0);
    chk("rst_stall", stall, 0);
    chk("rst_rdvalid", rd_valid, 0);
    chk("rst_rdval", rd_val, 0);
    @(negedge clk);
    rst = 1'b0;
    // basic MULT 300 * -7, result 16 cycles after start
    do_mult(16'd300, -16'sd7, 16, 0, 2'b00);
    quiet();
    chk("basic_hi", hi, 16'hFFFF);
    chk("basic_lo", lo, 16'hF7CC);
    idle_op(OP_MFHI, 1'b0);
    // interlock: MFLO held from the cycle after MULT
    do_mult(16'd1234, 16'd77, 9, 2, OP_MFLO);
    idle_op(OP_MFLO, 1'b0);
    quiet();
    // back-to-back MULT, second stalls then is accepted
    do_mult(16'd3, 16'd4, 5, 2, OP_MULT);
    do_mult(-16'sd2, 16'd5, 7, 0, 2'b00);
    quiet();
    chk("b2b_hi", hi, 16'hFFFF);
    chk("b2b_lo", lo, 16'hFFF6);
    // result in the final timeout cycle wins over the timeout
    do_mult(16'h7FFF, 16'h8000, TO, 1, 2'b00);
    quiet();
    chk("edge_err", err, 0);
    // reserved op while busy never stalls
    do_mult(16'h8000, 16'h8000, 3, 2, 2'b11);
    idle_op(2'b11, 1'b1);
    // random operands, latencies and interleaved ops
    for (int i = 0; i < 20; i++) begin
      do_mult(W'($urandom), W'($urandom), $urandom_range(2, TO), 1, 2'b00);
      idle_op(2'($urandom_range(1, 3)), 1'($urandom));
    end
    // timeout: multiplier never answers
    do_mult(16'd9, 16'd9, 0, 2, OP_MFHI);
    quiet();
    chk("to_err", err, 1);
    do_mult(16'd6, 16'd7, 4, 0, 2'b00);
    quiet();
    // asynchronous reset mid-BUSY
    @(negedge clk);
    op_valid = 1'b1; op = OP_MULT; rs_val = 16'd11; rt_val = 16'd13;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (5) @(negedge clk);
    op_valid = 1'b1; op = OP_MFHI;
    #1;
    chk("pre_rst_stall", stall, 1);
    #1 rst = 1'b1;
    #1;
    m_hi = '0; m_lo = '0; m_err = 1'b0;
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    chk("arst_stall", stall, 0);
    chk("arst_err", err, 0);
    chk("arst_start", mul_start, 0);
    chk("arst_rdval", rd_val, 0);
    @(negedge clk);
    rst = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    mul_valid = 1'b1; mul_result = 32'h1234_5678;
    quiet();
    quiet();
    do_mult(-16'sd100, -16'sd100, 12, 1, 2'b00);
    idle_op(OP_MFLO, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
